uart_tx_scheduler: RTL
======================

Name: uart_tx_scheduler

Overview:
Round-robin scheduler that shares one Uart_Tx transmitter between NUM_REQ byte requesters on a half-duplex line. It captures the granted byte and drives the transmitter's DV/byte inputs. It also controls the line-driver enable with setup/hold guard times and blocks new grants while the receiver owns the line. It sits between the host-side byte sources and the transmitter, in the same clock domain.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
SETUP_CLKS, 2, cycles o_Tx_En is high before the DV pulse (>=1)
HOLD_CLKS, 4, cycles o_Tx_En stays high after transmitter done is seen (>=1)
TIMEOUT_CLKS, 1024, watchdog limit on cycles from the DV pulse to done; must exceed 10*CLKS_PER_BIT+2

Ports:
i_Clock  in  1  system clock
i_Reset  in  1  synchronous, active-high reset
i_Req  in  NUM_REQ  per-requester byte-valid, level; held until the requester's ack
i_Req_Byte  in  8*NUM_REQ  byte for requester k in bits [8k+7:8k]
o_Ack  out  NUM_REQ  one-hot, one-cycle pulse; requester's byte captured
o_Grant_Idx  out  3  index of the current/last granted requester
o_Busy  out  1  scheduler not in IDLE
o_Tx_DV  out  1  to transmitter i_Tx_DV; one-cycle pulse
o_Tx_Byte  out  8  to transmitter i_Tx_Byte; holding register
i_Tx_Active  in  1  from transmitter o_Tx_Active
i_Tx_Done  in  1  from transmitter o_Tx_Done
i_Rx_Busy  in  1  receiver is mid-frame and owns the line
o_Tx_En  out  1  line-driver enable
o_Collision  out  1  one-cycle pulse; i_Rx_Busy seen while o_Tx_En high
o_Timeout  out  1  one-cycle pulse; watchdog expired

Behaviour:
- Reset (synchronous, active-high, i_Reset sampled on posedge i_Clock):
  - All outputs go to 0: o_Ack, o_Grant_Idx, o_Busy, o_Tx_DV, o_Tx_Byte, o_Tx_En, o_Collision, o_Timeout.
  - The round-robin pointer resets so requester 0 has highest priority.
  - State goes to IDLE and all counters clear.
  - Reset mid-transfer aborts immediately. o_Tx_En drops the next cycle.
  - The transmitter has no reset, so IDLE does not grant while i_Tx_Active=1.
- States: IDLE, SETUP, LAUNCH, WAIT_DONE, HOLD.
- IDLE:
  - Grant condition: i_Req!=0, i_Rx_Busy=0, i_Tx_Active=0 and i_Tx_Done=0.
  - Winner is the first set i_Req bit at or after the pointer, searching upward with wrap.
  - On grant, in the same edge:
    - o_Tx_Byte <= winner's byte; o_Ack[winner] pulses.
    - o_Grant_Idx <= winner; pointer <= winner+1 mod NUM_REQ.
    - o_Tx_En <= 1; state -> SETUP.
  - If i_Req and i_Rx_Busy rise in the same cycle, there is no grant.
- SETUP: counts SETUP_CLKS cycles with o_Tx_En=1, then -> LAUNCH.
- LAUNCH:
  - o_Tx_DV=1 for exactly this one cycle.
  - State -> WAIT_DONE and the watchdog clears.
  - Latency: the first o_Tx_DV is SETUP_CLKS+1 cycles after the grant edge.
- WAIT_DONE:
  - The watchdog increments every cycle.
  - On i_Tx_Done=1 -> HOLD. The transmitter holds done for 2 cycles; only the first one counts.
  - If the watchdog reaches TIMEOUT_CLKS-1 without done: pulse o_Timeout, drop o_Tx_En, -> IDLE.
- HOLD:
  - Counts HOLD_CLKS cycles with o_Tx_En=1, then o_Tx_En <= 0 and state -> IDLE.
  - Back-to-back requests are re-arbitrated from IDLE. The minimum gap between frames on the line is HOLD_CLKS+SETUP_CLKS+2 cycles.
- Collision:
  - o_Collision pulses on the rising edge of (i_Rx_Busy & o_Tx_En).
  - The transfer is not aborted; the flag is reporting only.
- Requests:
  - Dropping i_Req before ack is permitted; that requester loses its turn.
  - Requests arriving while o_Busy=1 wait; no queueing beyond the requester's own level.
- Widths:
  - Counters are sized with $clog2 of their parameter+1.
  - The pointer and o_Grant_Idx are 3 bits; upper bits are 0 when NUM_REQ<8.
- o_Busy = (state != IDLE), registered.

Decomposition:
- Shared package uart_pkg:
  - State encoding localparams (S_IDLE..S_HOLD, 3 bits).
  - Default SETUP/HOLD/TIMEOUT constants.
  - CLKS_PER_BIT shared with the transmitter.
- One sub-module, rr_arbiter_comb: combinational round-robin priority pick.
  - Inputs: request vector and pointer.
  - Outputs: one-hot grant and index.
  - It is reused later by the RX-side consumers.

Test Plan:
- Single request (a): i_Req=4'b0001, byte 8'hA5.
  - Ack[0] pulses at grant.
  - o_Tx_En rises with the grant.
  - o_Tx_DV pulses 3 cycles later.
  - The instantiated Uart_Tx (CLKS_PER_BIT=87) serialises A5.
  - o_Tx_En falls 4 cycles after the first done cycle.
- Single request (b): o_Busy=1 from the grant edge until HOLD exits.
- Fairness: all four requesters held with bytes 11/22/33/44.
  - Grant order is 0,1,2,3,0.
  - o_Grant_Idx tracks each grant.
  - Exactly one ack per frame.
- Half-duplex block: i_Rx_Busy=1 with i_Req=4'b0100.
  - No ack while busy.
  - Grant to 2 occurs the cycle after i_Rx_Busy falls.
  - Raising i_Rx_Busy during WAIT_DONE gives one o_Collision pulse and the frame still completes.
- Timeout: stub transmitter that never asserts done.
  - o_Timeout pulses 1024 cycles after DV.
  - o_Tx_En falls and the state returns to IDLE.
- Reset mid-frame: assert i_Reset during data bit 3.
  - The next edge clears all outputs to 0.
  - No grant until i_Tx_Active=0.
  - The pointer is back at 0, so i_Req=4'b1001 grants 0 first.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: scheduler state encoding, default guard/watchdog
// timing and the bit period used by the transmitter.
package uart_pkg;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_SETUP     = 3'd1,
    S_LAUNCH    = 3'd2,
    S_WAIT_DONE = 3'd3,
    S_HOLD      = 3'd4
  } state_t;

  localparam int CLKS_PER_BIT     = 87;
  localparam int DEF_SETUP_CLKS   = 2;
  localparam int DEF_HOLD_CLKS    = 4;
  localparam int DEF_TIMEOUT_CLKS = 1024;

  // Round-robin successor of a requester index, wrapping at n.
  function automatic logic [2:0] rr_next(input logic [2:0] idx, input int n);
    return (int'(idx) + 1 >= n) ? 3'd0 : idx + 3'd1;
  endfunction

endpackage

// File: rtl/uart_tx_scheduler_if.sv
// Bundle between byte requesters, the scheduler, the shared transmitter and
// the half-duplex line; master is the scheduler side.
interface uart_tx_scheduler_if #(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0]   req;
  logic [8*NUM_REQ-1:0] req_byte;
  logic [NUM_REQ-1:0]   ack;
  logic [2:0]           grant_idx;
  logic                 busy;
  logic                 tx_dv;
  logic [7:0]           tx_byte;
  logic                 tx_active;
  logic                 tx_done;
  logic                 rx_busy;
  logic                 tx_en;
  logic                 collision;
  logic                 timeout;

  modport master (
    input  req, req_byte, tx_active, tx_done, rx_busy,
    output ack, grant_idx, busy, tx_dv, tx_byte, tx_en, collision, timeout
  );

  modport slave (
    output req, req_byte, tx_active, tx_done, rx_busy,
    input  ack, grant_idx, busy, tx_dv, tx_byte, tx_en, collision, timeout
  );
endinterface

// File: rtl/rr_arbiter_comb.sv
// Combinational round-robin pick: first set request at or above ptr, wrapping.
module rr_arbiter_comb #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [2:0]         ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [2:0]         idx,
  output logic               valid
);
  int k;

  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so
    // no path through the loop can leave a value held (which infers a latch).
    gnt   = '0;
    idx   = '0;
    valid = 1'b0;
    k     = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      k = int'(ptr) + i;
      if (k >= NUM_REQ) k = k - NUM_REQ;
      if (!valid && req[k]) begin
        valid  = 1'b1;
        gnt[k] = 1'b1;
        idx    = 3'(k);
      end
    end
  end
endmodule

// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler sharing one UART transmitter between NUM_REQ byte
// sources, with line-driver guard times and receiver-ownership blocking.
module uart_tx_scheduler
  import uart_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int SETUP_CLKS   = DEF_SETUP_CLKS,
  parameter int HOLD_CLKS    = DEF_HOLD_CLKS,
  parameter int TIMEOUT_CLKS = DEF_TIMEOUT_CLKS
) (
  input logic                 i_Clock,
  input logic                 i_Reset,
  uart_tx_scheduler_if.master bus
);
  localparam int SW = $clog2(SETUP_CLKS + 1);
  localparam int HW = $clog2(HOLD_CLKS + 1);
  localparam int WW = $clog2(TIMEOUT_CLKS + 1);

  state_t             state_q, state_d;
  logic [2:0]         ptr_q, ptr_d;
  logic [SW-1:0]      setup_cnt_q, setup_cnt_d;
  logic [HW-1:0]      hold_cnt_q, hold_cnt_d;
  logic [WW-1:0]      wd_q, wd_d;
  logic [NUM_REQ-1:0] arb_gnt, ack_q, ack_d;
  logic [2:0]         arb_idx, grant_idx_q, grant_idx_d;
  logic [7:0]         tx_byte_q, tx_byte_d;
  logic               arb_valid, grant_ok, setup_end, hold_end, wd_end;
  logic               busy_q, busy_d, tx_dv_q, tx_dv_d, tx_en_q, tx_en_d;
  logic               coll_q, coll_d, overlap_q, overlap_d, timeout_q, timeout_d;

  rr_arbiter_comb #(.NUM_REQ(NUM_REQ)) u_arb (
    .req   (bus.req),
    .ptr   (ptr_q),
    .gnt   (arb_gnt),
    .idx   (arb_idx),
    .valid (arb_valid)
  );

  // The transmitter has no reset, so never launch while it is still busy.
  assign grant_ok  = arb_valid & ~bus.rx_busy & ~bus.tx_active & ~bus.tx_done;
  assign setup_end = (setup_cnt_q == SW'(SETUP_CLKS - 1));
  assign hold_end  = (hold_cnt_q >= HW'(HOLD_CLKS - 1));
  assign wd_end    = (wd_q == WW'(TIMEOUT_CLKS - 1));

  always_ff @(posedge i_Clock) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (i_Reset) begin
      state_q     <= S_IDLE;
      ptr_q       <= '0;
      setup_cnt_q <= '0;
      hold_cnt_q  <= '0;
      wd_q        <= '0;
      ack_q       <= '0;
      grant_idx_q <= '0;
      tx_byte_q   <= '0;
      busy_q      <= 1'b0;
      tx_dv_q     <= 1'b0;
      tx_en_q     <= 1'b0;
      coll_q      <= 1'b0;
      overlap_q   <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      setup_cnt_q <= setup_cnt_d;
      hold_cnt_q  <= hold_cnt_d;
      wd_q        <= wd_d;
      ack_q       <= ack_d;
      grant_idx_q <= grant_idx_d;
      tx_byte_q   <= tx_byte_d;
      busy_q      <= busy_d;
      tx_dv_q     <= tx_dv_d;
      tx_en_q     <= tx_en_d;
      coll_q      <= coll_d;
      overlap_q   <= overlap_d;
      timeout_q   <= timeout_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    setup_cnt_d = (state_q == S_SETUP) ? setup_cnt_q + 1'b1 : '0;
    // The first done cycle already counts toward the hold time.
    hold_cnt_d  = (state_q == S_HOLD) ? hold_cnt_q + 1'b1 : HW'(1);
    wd_d        = (state_q == S_WAIT_DONE) ? wd_q + 1'b1 : '0;
    unique case (state_q)
      S_IDLE: if (grant_ok) begin
        state_d = S_SETUP;
        ptr_d   = rr_next(arb_idx, NUM_REQ);
      end
      S_SETUP:     if (setup_end) state_d = S_LAUNCH;
      S_LAUNCH:    state_d = S_WAIT_DONE;
      S_WAIT_DONE: if (bus.tx_done) state_d = S_HOLD;
                   else if (wd_end) state_d = S_IDLE;
      S_HOLD:      if (hold_end) state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ack_d       = '0;
    grant_idx_d = grant_idx_q;
    tx_byte_d   = tx_byte_q;
    tx_en_d     = tx_en_q;
    timeout_d   = 1'b0;
    tx_dv_d     = (state_q == S_LAUNCH);
    busy_d      = (state_d != S_IDLE);
    overlap_d   = bus.rx_busy & tx_en_q;
    coll_d      = overlap_d & ~overlap_q;
    if (state_q == S_IDLE && grant_ok) begin
      ack_d       = arb_gnt;
      grant_idx_d = arb_idx;
      tx_en_d     = 1'b1;
      for (int k = 0; k < NUM_REQ; k++)
        if (arb_gnt[k]) tx_byte_d = bus.req_byte[8*k +: 8];
    end
    if (state_q == S_WAIT_DONE && !bus.tx_done && wd_end) begin
      timeout_d = 1'b1;
      tx_en_d   = 1'b0;
    end
    if (state_q == S_HOLD && hold_end) tx_en_d = 1'b0;
  end

  assign bus.ack       = ack_q;
  assign bus.grant_idx = grant_idx_q;
  assign bus.busy      = busy_q;
  assign bus.tx_dv     = tx_dv_q;
  assign bus.tx_byte   = tx_byte_q;
  assign bus.tx_en     = tx_en_q;
  assign bus.collision = coll_q;
  assign bus.timeout   = timeout_q;
endmodule
